// File: rtl/fire_expand1_sched_if.sv
// Handshake/bus bundle between the fire4/fire5 expand-1x1 scheduler and its
// surroundings (squeeze stages, MAC array, weight ROM, ofm RAM).
interface fire_expand1_sched_if #(
   parameter int CW = 5,
   parameter int PW = 10
);
   logic          fire4_start;
   logic          fire5_start;
   logic          out_ready;
   logic          ram_feedback;
   logic          fire4_en;
   logic          fire5_en;
   logic          mac_en;
   logic          mac_clr;
   logic [CW-1:0] rom_addr;
   logic [PW-1:0] ifm_pix;
   logic          ofm_sample;
   logic [PW-1:0] ofm_pix;
   logic          fire4_done;
   logic          fire5_done;
   logic          busy;

   modport master (
      output fire4_start, fire5_start, out_ready, ram_feedback,
      input  fire4_en, fire5_en, mac_en, mac_clr, rom_addr, ifm_pix,
             ofm_sample, ofm_pix, fire4_done, fire5_done, busy
   );

   modport slave (
      input  fire4_start, fire5_start, out_ready, ram_feedback,
      output fire4_en, fire5_en, mac_en, mac_clr, rom_addr, ifm_pix,
             ofm_sample, ofm_pix, fire4_done, fire5_done, busy
   );
endinterface

// File: rtl/fire_expand1_sched.sv
// Arbiter/sequencer granting the shared expand-1x1 MAC array to fire4 or fire5
// and walking channel/pixel addresses for the granted layer.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  S_IDLE    | no layer granted; grant a pending request (fire4 first)
//  S_RUN     | issue (pix, ch) addresses; pixel boundary waits on out_ready
//  S_DRAIN   | MAC pipeline flush, final ofm_sample, no new addresses
//  S_WAIT_FB | layer computed; wait for the ofm RAM acknowledge
module fire_expand1_sched #(
   parameter int CHIN    = 32,
   parameter int WOUT    = 32,
   parameter int MAC_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   fire_expand1_sched_if.slave bus
);
   localparam int CW = $clog2(CHIN);
   localparam int PW = $clog2(WOUT * WOUT);
   localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [CW-1:0] CH_LAST   = CW'(CHIN - 1);
   localparam logic [PW-1:0] PIX_LAST  = PW'(WOUT * WOUT - 1);
   localparam logic [DW-1:0] DRAIN_TOP = DW'(MAC_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_WAIT_FB
   } state_t;

   state_t        state_q, state_d;
   logic          layer_q, layer_d;   // 0 = fire4, 1 = fire5
   logic [CW-1:0] ch_q, ch_d;
   logic [PW-1:0] pix_q, pix_d;
   logic [DW-1:0] drain_q, drain_d;
   logic          pend4_q, pend4_d;
   logic          pend5_q, pend5_d;
   logic          done4_q, done4_d;
   logic          done5_q, done5_d;

   logic [MAC_LAT-1:0] samp_q;
   logic [PW-1:0]      spix_q [MAC_LAT];

   logic busy_c;
   logic acc4, acc5, p4, p5;
   logic mac_en_c, issue_last, advance;
   logic do_grant, grant_l;

   assign busy_c = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         layer_q <= 1'b0;
         ch_q    <= '0;
         pix_q   <= '0;
         drain_q <= '0;
         pend4_q <= 1'b0;
         pend5_q <= 1'b0;
         done4_q <= 1'b0;
         done5_q <= 1'b0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         ch_q    <= ch_d;
         pix_q   <= pix_d;
         drain_q <= drain_d;
         pend4_q <= pend4_d;
         pend5_q <= pend5_d;
         done4_q <= done4_d;
         done5_q <= done5_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      layer_d    = layer_q;
      ch_d       = ch_q;
      pix_d      = pix_q;
      drain_d    = drain_q;
      done4_d    = done4_q;
      done5_d    = done5_q;
      mac_en_c   = 1'b0;
      issue_last = 1'b0;
      advance    = 1'b0;
      do_grant   = 1'b0;
      grant_l    = 1'b0;

      // A start counts only for a layer that is neither pending, running nor done;
      // it is visible to the grant logic in the same cycle it arrives.
      acc4    = bus.fire4_start && !pend4_q && !done4_q && !(busy_c && !layer_q);
      acc5    = bus.fire5_start && !pend5_q && !done5_q && !(busy_c && layer_q);
      p4      = pend4_q || acc4;
      p5      = pend5_q || acc5;
      pend4_d = p4;
      pend5_d = p5;

      case (state_q)
         S_IDLE: begin
            if (p4 || p5) begin
               do_grant = 1'b1;
               grant_l  = !p4;
            end
         end
         S_RUN: begin
            advance = (ch_q != '0) || bus.out_ready;
            if (advance) begin
               mac_en_c = 1'b1;
               if (ch_q == CH_LAST) begin
                  issue_last = 1'b1;
                  ch_d       = '0;
                  pix_d      = pix_q + PW'(1);
                  if (pix_q == PIX_LAST) begin
                     state_d = S_DRAIN;
                     drain_d = DRAIN_TOP;
                  end
               end else begin
                  ch_d = ch_q + CW'(1);
               end
            end
         end
         S_DRAIN: begin
            mac_en_c = 1'b1;
            if (drain_q == '0) begin
               state_d = S_WAIT_FB;
               if (layer_q) done5_d = 1'b1;
               else         done4_d = 1'b1;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         S_WAIT_FB: begin
            if (bus.ram_feedback) begin
               if (layer_q ? p4 : p5) begin
                  do_grant = 1'b1;
                  grant_l  = !layer_q;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_grant) begin
         state_d = S_RUN;
         layer_d = grant_l;
         ch_d    = '0;
         pix_d   = '0;
         if (grant_l) pend5_d = 1'b0;
         else         pend4_d = 1'b0;
      end
   end

   // Fixed-latency tag pipe: marks the cycle the accumulator holds a complete pixel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         samp_q <= '0;
         for (int i = 0; i < MAC_LAT; i++) spix_q[i] <= '0;
      end else begin
         samp_q[0] <= issue_last;
         spix_q[0] <= pix_q;
         for (int i = 1; i < MAC_LAT; i++) begin
            samp_q[i] <= samp_q[i-1];
            spix_q[i] <= spix_q[i-1];
         end
      end
   end

   assign bus.busy       = busy_c;
   assign bus.fire4_en   = busy_c && !layer_q;
   assign bus.fire5_en   = busy_c && layer_q;
   assign bus.mac_en     = mac_en_c;
   assign bus.rom_addr   = (state_q == S_RUN) ? ch_q  : '0;
   assign bus.ifm_pix    = (state_q == S_RUN) ? pix_q : '0;
   assign bus.ofm_sample = samp_q[MAC_LAT-1];
   assign bus.mac_clr    = samp_q[MAC_LAT-1];
   assign bus.ofm_pix    = samp_q[MAC_LAT-1] ? spix_q[MAC_LAT-1] : '0;
   assign bus.fire4_done = done4_q;
   assign bus.fire5_done = done5_q;
endmodule

// File: tb/tb_fire_expand1_sched.sv
// Directed + randomized bench for fire_expand1_sched; expected outputs come from
// closed-form schedule arithmetic (grant cycle, stall windows, fixed MAC latency).
module tb_fire_expand1_sched;
   localparam int CHIN    = 32;
   localparam int WOUT    = 32;
   localparam int MAC_LAT = 2;
   localparam int NPIX    = WOUT * WOUT;
   localparam int CW      = 5;
   localparam int PW      = 10;
   localparam int BIG     = 1 << 30;
   localparam int K_NONE  = 0;
   localparam int K_STALL = 1;
   localparam int K_ISSUE = 2;
   localparam int K_DRAIN = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fire_expand1_sched_if #(.CW(CW), .PW(PW)) bus ();

   fire_expand1_sched #(.CHIN(CHIN), .WOUT(WOUT), .MAC_LAT(MAC_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit mon_on   = 1'b0;

   // layer under observation: first issue cycle and stall list (pixel, length)
   int cur_f;
   int cur_sp[$];
   int cur_sl[$];
   int next_pix;
   int dut_samples;
   int en_lo[2];
   int en_hi[2];
   int done_cyc[2];
   // stimulus schedule (absolute cycles)
   int s4_q[$];
   int s5_q[$];
   int fb_q[$];
   int low_lo[$];
   int low_hi[$];
   int nz_lo, nz_hi;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit in_q(input int q[$], input int v);
      foreach (q[i]) if (q[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int samp_cyc(input int p);
      int s;
      s = cur_f + CHIN * p + (CHIN - 1) + MAC_LAT;
      for (int i = 0; i < cur_sp.size(); i++) if (cur_sp[i] <= p) s += cur_sl[i];
      return s;
   endfunction

   function automatic void exp_issue(input int c, output int kind, output int ch, output int pix);
      int t, shift, bs, w;
      kind  = K_NONE;
      ch    = 0;
      pix   = 0;
      shift = 0;
      if (c < cur_f) return;
      t = c - cur_f;
      for (int i = 0; i < cur_sp.size(); i++) begin
         bs = CHIN * cur_sp[i] + shift;
         if (t < bs) break;
         if (t < bs + cur_sl[i]) begin
            kind = K_STALL;
            pix  = cur_sp[i];
            return;
         end
         shift += cur_sl[i];
      end
      w = t - shift;
      if (w < CHIN * NPIX) begin
         kind = K_ISSUE;
         ch   = w % CHIN;
         pix  = w / CHIN;
      end else if (w < CHIN * NPIX + MAC_LAT) begin
         kind = K_DRAIN;
      end
   endfunction

   task automatic model_clear();
      cur_f = BIG;
      cur_sp.delete();
      cur_sl.delete();
      next_pix    = 0;
      dut_samples = 0;
      for (int i = 0; i < 2; i++) begin
         en_lo[i]    = BIG;
         en_hi[i]    = BIG;
         done_cyc[i] = BIG;
      end
      s4_q.delete();
      s5_q.delete();
      fb_q.delete();
      low_lo.delete();
      low_hi.delete();
      nz_lo = BIG;
      nz_hi = BIG;
   endtask

   task automatic mon();
      int  kind, ch, pix;
      bit  s_exp, e4, e5;
      exp_issue(cyc, kind, ch, pix);
      chk("mac_en", 32'(bus.mac_en), 32'(kind == K_ISSUE || kind == K_DRAIN));
      chk("rom_addr", 32'(bus.rom_addr), (kind == K_ISSUE || kind == K_STALL) ? 32'(ch) : 32'd0);
      chk("ifm_pix", 32'(bus.ifm_pix), (kind == K_ISSUE || kind == K_STALL) ? 32'(pix) : 32'd0);
      s_exp = (next_pix < NPIX) && (cyc == samp_cyc(next_pix));
      chk("ofm_sample", 32'(bus.ofm_sample), 32'(s_exp));
      chk("mac_clr", 32'(bus.mac_clr), 32'(s_exp));
      if (bus.ofm_sample === 1'b1) dut_samples++;
      if (s_exp) begin
         chk("ofm_pix", 32'(bus.ofm_pix), 32'(next_pix));
         next_pix++;
      end
      e4 = (cyc >= en_lo[0]) && (cyc <= en_hi[0]);
      e5 = (cyc >= en_lo[1]) && (cyc <= en_hi[1]);
      chk("fire4_en", 32'(bus.fire4_en), 32'(e4));
      chk("fire5_en", 32'(bus.fire5_en), 32'(e5));
      chk("busy", 32'(bus.busy), 32'(e4 || e5));
      chk("fire4_done", 32'(bus.fire4_done), 32'(cyc >= done_cyc[0]));
      chk("fire5_done", 32'(bus.fire5_done), 32'(cyc >= done_cyc[1]));
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_fire4_en"}, 32'(bus.fire4_en), 32'd0);
      chk({tag, "_fire5_en"}, 32'(bus.fire5_en), 32'd0);
      chk({tag, "_mac_en"}, 32'(bus.mac_en), 32'd0);
      chk({tag, "_mac_clr"}, 32'(bus.mac_clr), 32'd0);
      chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
      chk({tag, "_ifm_pix"}, 32'(bus.ifm_pix), 32'd0);
      chk({tag, "_ofm_sample"}, 32'(bus.ofm_sample), 32'd0);
      chk({tag, "_ofm_pix"}, 32'(bus.ofm_pix), 32'd0);
      chk({tag, "_fire4_done"}, 32'(bus.fire4_done), 32'd0);
      chk({tag, "_fire5_done"}, 32'(bus.fire5_done), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic cyc_step();
      @(negedge clk);
      if (mon_on) mon();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive();
      bus.fire4_start  = in_q(s4_q, cyc);
      bus.fire5_start  = in_q(s5_q, cyc);
      bus.ram_feedback = in_q(fb_q, cyc);
      bus.out_ready    = 1'b1;
      for (int i = 0; i < low_lo.size(); i++)
         if (cyc >= low_lo[i] && cyc <= low_hi[i]) bus.out_ready = 1'b0;
      if (cyc >= nz_lo && cyc <= nz_hi) bus.out_ready = 1'($urandom_range(1, 0));
   endtask

   task automatic run_until(input int last);
      while (cyc <= last) begin
         drive();
         cyc_step();
      end
   endtask

   task automatic do_reset(input string tag);
      mon_on           = 1'b0;
      rst              = 1'b0;
      bus.fire4_start  = 1'b0;
      bus.fire5_start  = 1'b0;
      bus.ram_feedback = 1'b0;
      bus.out_ready    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_chk(tag);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
      model_clear();
      mon_on = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ack, f5, q, l2, ack5, b1, rc;

      // ---- phase A: fire4 alone, then fire5 with stalls ----
      do_reset("rst_init");
      cur_f       = 6;
      done_cyc[0] = samp_cyc(NPIX - 1) + 1;
      en_lo[0]    = 6;
      n_ack       = done_cyc[0] + int'($urandom_range(40, 0));
      en_hi[0]    = n_ack;
      en_lo[1]    = n_ack + 1;
      s4_q.push_back(5);
      s4_q.push_back(int'($urandom_range(32700, 10)));
      s5_q.push_back(int'($urandom_range(32700, 10)));
      fb_q.push_back(2);
      fb_q.push_back(int'($urandom_range(32700, 7)));
      fb_q.push_back(done_cyc[0] - 2);
      fb_q.push_back(n_ack);
      run_until(n_ack);
      chk("f4_sample_count", 32'(dut_samples), 32'(NPIX));

      f5 = n_ack + 1;
      q  = int'($urandom_range(1000, 150));
      l2 = int'($urandom_range(15, 1));
      cur_f = f5;
      cur_sp.push_back(100);
      cur_sl.push_back(10);
      cur_sp.push_back(q);
      cur_sl.push_back(l2);
      next_pix    = 0;
      dut_samples = 0;
      done_cyc[1] = samp_cyc(NPIX - 1) + 1;
      ack5        = done_cyc[1] + int'($urandom_range(20, 0));
      en_hi[1]    = ack5;
      b1          = f5 + CHIN * 100;
      low_lo.push_back(b1);
      low_hi.push_back(b1 + 9);
      low_lo.push_back(f5 + CHIN * q + 10);
      low_hi.push_back(f5 + CHIN * q + 10 + l2 - 1);
      nz_lo = b1 + 11;
      nz_hi = b1 + 40;
      s4_q.push_back(f5 + int'($urandom_range(20000, 50)));
      s4_q.push_back(ack5 + 3);
      s5_q.push_back(f5 + int'($urandom_range(20000, 50)));
      s5_q.push_back(ack5 + 4);
      fb_q.push_back(f5 + int'($urandom_range(30000, 5)));
      fb_q.push_back(ack5);
      run_until(ack5 + 10);
      chk("f5_sample_count", 32'(dut_samples), 32'(NPIX));

      // ---- phase B: simultaneous starts, async reset mid-layer, clean restart ----
      do_reset("rst_after_layers");
      s4_q.push_back(3);
      s5_q.push_back(3);
      cur_f       = 4;
      en_lo[0]    = 4;
      done_cyc[0] = samp_cyc(NPIX - 1) + 1;
      rc = 4 + CHIN * 500 + int'($urandom_range(31, 0));
      run_until(rc);
      #2;
      rst = 1'b0;
      #1;
      mon_on = 1'b0;
      reset_chk("rst_midrun");
      do_reset("rst_midrun_hold");
      s5_q.push_back(3);
      cur_f       = 4;
      en_lo[1]    = 4;
      done_cyc[1] = samp_cyc(NPIX - 1) + 1;
      run_until(4 + CHIN * 3 + 40);
      chk("f5_restart_samples", 32'(dut_samples), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
